game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
Top-level game sequencer for the brick-breaker datapath. It drives the 3-bit game state consumed by ball_control and requests brick-pattern loads. It tracks lives, level and score, and issues one-cycle skill grants that ball_control ORs into its skill_remain register. It sits between the input/debounce logic and ball_control, and runs at the slow game tick.

Parameters:
LIVES, 3, lives loaded on game start (1..3)
LEVELS, 3, number of brick patterns (1..4)
SERVE_TICKS, 48, auto-serve delay in clk_22 ticks
PAUSE_TICKS, 24, dwell in LOST/CLEAR states
SKILL_STEP, 20, points per skill grant
LOST_Y, 530, ball bottom edge beyond which the ball is lost
BALL_H, 10, ball height in pixels

Ports:
clk_22  in  1  game tick clock
rst  in  1  reset, asynchronous, active-high
start_btn  in  1  debounced level; rising edge detected internally
ball_y  in  10  current ball top y
ball_vy  in  10  current ball y speed
ball_dir_down  in  1  ball_dir[0] from datapath; 1 = moving down
bricks  in  1440  current brick array, 480 cells x 3 bits
collision_trig  in  4  sum of brick values hit this tick
load_done  in  1  brick loader finished writing the pattern
state  out  3  game state to ball_control
lives  out  2  remaining lives
level  out  2  current level index
score  out  14  score, saturating at 9999
skill  out  3  one-hot skill grant pulse
brick_load  out  1  pattern load request
brick_pattern  out  2  pattern index, equal to level

Behaviour:
- Clocking: all flops on posedge clk_22, async reset on rst.
- Reset values: state=MENU, lives=LIVES, level=0, score=0, skill=0, brick_load=0, timer=0, skill_acc=0, skill_ptr=001, start_q=0.
- start_pulse = start_btn & ~start_q. start_q is registered each tick.
- ball_lost = ball_dir_down & ({1'b0,ball_y}+ball_vy+BALL_H > LOST_Y). Computed in 11 bits; this must match the datapath's own fall test.
- cleared = ~|bricks.
- State encoding (3 bits): MENU=0, LOAD=1, SERVE=2, PLAY=3, LOST=4, CLEAR=5, OVER=6, WIN=7. PLAY must equal 3, because the datapath advances only in state 3.
- MENU: on start_pulse, set lives=LIVES, level=0, score=0, skill_acc=0, then go to LOAD.
- LOAD: brick_load=1 registered while in LOAD. Go to SERVE on the tick load_done=1; brick_load drops with the transition. There is no timeout.
- SERVE: timer counts up from 0. Go to PLAY on start_pulse, or when timer==SERVE_TICKS-1, whichever comes first. The timer clears on exit.
- PLAY, transition priority:
  - ball_lost: go to LOST.
  - else cleared: go to CLEAR.
  - else stay in PLAY.
  - A lost ball beats a cleared board when both occur on the same tick.
- LOST: dwell PAUSE_TICKS ticks. On exit, lives decrements. If lives was 1, go to OVER (lives=0); otherwise go to SERVE.
- CLEAR: dwell PAUSE_TICKS ticks. On exit, if level==LEVELS-1 go to WIN; otherwise level++ and go to LOAD.
- OVER/WIN: hold all counters. On start_pulse go to MENU. Score stays visible until the next game start.
- Score: added only while state==PLAY, including the tick that leaves PLAY.
  - score_next = min(score+collision_trig, 9999).
- Skill grants, also PLAY-only:
  - sum = skill_acc+collision_trig (6 bits).
  - If sum>=SKILL_STEP: skill_acc=sum-SKILL_STEP, skill=skill_ptr for exactly one tick, and skill_ptr rotates 001→010→100→001.
  - Else skill_acc=sum and skill=0.
  - skill_acc keeps accumulating after score saturates.
- skill is 0 in every state other than PLAY.
- start_btn held high through a transition produces no second pulse.
- Reset asserted mid-game returns everything to reset values immediately. brick_load deasserts asynchronously.
- brick_pattern = level at all times.

Decomposition:
- game_pkg holds:
  - the state encoding localparams (ST_MENU..ST_WIN);
  - screen constants H=640, V=480;
  - BALL_H and LOST_Y;
  - brick geometry: cell 32x20, 3 bits per cell, 20 cells per row.
- ball_control must take its PLAY constant from the same package.
- One sub-module, skill_award, holds skill_acc, skill_ptr and the grant pulse.
  - Inputs: clk_22, rst, en (state==PLAY), clear (game start), pts[3:0].
  - Output: skill[2:0].

Test Plan:
- Reset, then start_btn high for 5 ticks → state MENU→LOAD, one start_pulse only, brick_load=1. load_done pulse → SERVE next tick, brick_load=0.
- In SERVE, no button → PLAY after exactly 48 ticks. Repeat with start_btn rising at tick 10 → PLAY at tick 11.
- In PLAY, ball_dir_down=1, ball_y=515, ball_vy=9 (515+9+10=534>530) → LOST. After 24 ticks lives 3→2, state SERVE. Repeat to lives=0 → OVER; start_pulse → MENU.
- In PLAY, bricks=0 and ball_lost on the same tick → LOST, not CLEAR. With bricks=0 alone at level 2 and LEVELS=3 → CLEAR, then WIN after 24 ticks.
- collision_trig=7 for 3 ticks → score=21, skill=001 pulse on tick 3, skill_acc=1. 20 more points → skill=010.
- score=9995 plus collision_trig=12 → score=9999. rst mid-LOAD → state=0, brick_load=0 without waiting for a clock edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants for the brick-breaker game: state encoding, screen and
// brick geometry, and the ball fall test used by both this sequencer and
// the ball datapath.
package game_pkg;

  // Game state encoding. ST_PLAY must stay 3: the ball datapath only
  // advances the ball while it sees state 3.
  typedef enum logic [2:0] {
    ST_MENU  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SERVE = 3'd2,
    ST_PLAY  = 3'd3,
    ST_LOST  = 3'd4,
    ST_CLEAR = 3'd5,
    ST_OVER  = 3'd6,
    ST_WIN   = 3'd7
  } game_state_e;

  // Screen size in pixels
  localparam int H = 640;
  localparam int V = 480;

  // Ball geometry and the bottom edge beyond which the ball counts as lost
  localparam int BALL_H = 10;
  localparam int LOST_Y = 530;

  // Brick array geometry: 32x20 pixel cells, 3 bits each, 20 cells per row
  localparam int CELL_W        = 32;
  localparam int CELL_H        = 20;
  localparam int CELL_BITS     = 3;
  localparam int CELLS_PER_ROW = 20;
  localparam int NUM_CELLS     = 480;
  localparam int BRICK_BITS    = NUM_CELLS * CELL_BITS;

  // Score ceiling
  localparam logic [13:0] SCORE_MAX = 14'd9999;

  // Ball fall test, done in 11 bits so y+vy+height cannot wrap. The ball
  // datapath calls the same function so both sides agree on the lost tick.
  function automatic logic ball_past_floor(input logic [9:0] y,
                                           input logic [9:0] vy,
                                           input int         ball_h,
                                           input int         lost_y);
    logic [10:0] bottom;
    bottom = {1'b0, y} + {1'b0, vy} + 11'(ball_h);
    return bottom > 11'(lost_y);
  endfunction

  // Score add that sticks at SCORE_MAX
  function automatic logic [13:0] score_add(input logic [13:0] score,
                                            input logic [3:0]  pts);
    logic [14:0] sum;
    sum = {1'b0, score} + 15'(pts);
    return (sum > 15'(SCORE_MAX)) ? SCORE_MAX : sum[13:0];
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Signal bundle between the game sequencer and its surroundings (debounced
// buttons, ball datapath, brick loader). master = surroundings,
// slave = game_flow_ctrl.
// There is no valid/ready pair on this bundle: inputs are sampled every
// clk_22 tick as levels, load_done is a level/pulse that the sequencer only
// looks at while brick_load is high, and every output is a registered level
// except skill, which is a one-tick pulse.
interface game_flow_ctrl_if;
  logic          start_btn;
  logic [9:0]    ball_y;
  logic [9:0]    ball_vy;
  logic          ball_dir_down;
  logic [1439:0] bricks;
  logic [3:0]    collision_trig;
  logic          load_done;
  logic [2:0]    state;
  logic [1:0]    lives;
  logic [1:0]    level;
  logic [13:0]   score;
  logic [2:0]    skill;
  logic          brick_load;
  logic [1:0]    brick_pattern;

  modport master (
    output start_btn, ball_y, ball_vy, ball_dir_down, bricks,
           collision_trig, load_done,
    input  state, lives, level, score, skill, brick_load, brick_pattern
  );

  modport slave (
    input  start_btn, ball_y, ball_vy, ball_dir_down, bricks,
           collision_trig, load_done,
    output state, lives, level, score, skill, brick_load, brick_pattern
  );
endinterface

// File: rtl/game_flow_ctrl_skill_award.sv
// Skill grant accumulator: collects points while the game is in PLAY and
// emits a one-tick one-hot grant each time SKILL_STEP points have built up,
// rotating through the three skills.
module skill_award
  import game_pkg::*;
#(
  parameter int SKILL_STEP = 20
) (
  input  logic       clk_22,
  input  logic       rst,
  input  logic       en,
  input  logic       clear,
  input  logic [3:0] pts,
  output logic [2:0] skill
);

  logic [5:0] skill_acc_q, skill_acc_d;
  logic [2:0] skill_ptr_q, skill_ptr_d;
  logic [2:0] skill_q, skill_d;
  logic [5:0] sum;

  // Accumulate points; on crossing the step, grant the pointed skill and rotate
  always_comb begin
    sum         = skill_acc_q + {2'b00, pts};
    skill_acc_d = skill_acc_q;
    skill_ptr_d = skill_ptr_q;
    skill_d     = 3'b000;
    if (clear) begin
      skill_acc_d = 6'd0;
    end else if (en) begin
      if (sum >= 6'(SKILL_STEP)) begin
        skill_acc_d = sum - 6'(SKILL_STEP);
        skill_d     = skill_ptr_q;
        skill_ptr_d = {skill_ptr_q[1:0], skill_ptr_q[2]};
      end else begin
        skill_acc_d = sum;
      end
    end
  end

  // Accumulator, pointer and grant registers
  always_ff @(posedge clk_22 or posedge rst) begin
    if (rst) begin
      skill_acc_q <= 6'd0;
      skill_ptr_q <= 3'b001;
      skill_q     <= 3'b000;
    end else begin
      skill_acc_q <= skill_acc_d;
      skill_ptr_q <= skill_ptr_d;
      skill_q     <= skill_d;
    end
  end

  assign skill = skill_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: walks MENU/LOAD/SERVE/PLAY/LOST/CLEAR/OVER/WIN,
// keeps lives, level and score, requests brick pattern loads and hands out
// skill grants through skill_award.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int LIVES       = 3,
  parameter int LEVELS      = 3,
  parameter int SERVE_TICKS = 48,
  parameter int PAUSE_TICKS = 24,
  parameter int SKILL_STEP  = 20,
  parameter int LOST_Y      = game_pkg::LOST_Y,
  parameter int BALL_H      = game_pkg::BALL_H
) (
  input logic        clk_22,
  input logic        rst,
  game_flow_ctrl_if.slave bus
);

  localparam int TW = 8;

  game_state_e   state_q, state_d;
  logic [1:0]    lives_q, lives_d;
  logic [1:0]    level_q, level_d;
  logic [13:0]   score_q, score_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          brick_load_q, brick_load_d;
  logic          start_q, start_d;

  logic       start_pulse;
  logic       ball_lost;
  logic       cleared;
  logic       game_start;
  logic       in_play;
  logic [2:0] skill_w;

  assign start_pulse = bus.start_btn & ~start_q;
  assign ball_lost   = bus.ball_dir_down &
                       ball_past_floor(bus.ball_y, bus.ball_vy, BALL_H, LOST_Y);
  assign cleared     = ~|bus.bricks;
  assign in_play     = (state_q == ST_PLAY);

  // Next-state, counter and load-request logic for the game sequence
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    level_d      = level_q;
    score_d      = score_q;
    timer_d      = timer_q;
    brick_load_d = 1'b0;
    start_d      = bus.start_btn;
    game_start   = 1'b0;
    case (state_q)
      ST_MENU: begin
        if (start_pulse) begin
          lives_d      = 2'(LIVES);
          level_d      = 2'd0;
          score_d      = 14'd0;
          game_start   = 1'b1;
          state_d      = ST_LOAD;
          brick_load_d = 1'b1;
        end
      end
      ST_LOAD: begin
        if (bus.load_done) begin
          state_d = ST_SERVE;
          timer_d = '0;
        end else begin
          brick_load_d = 1'b1;
        end
      end
      ST_SERVE: begin
        if (start_pulse || (timer_q == TW'(SERVE_TICKS - 1))) begin
          state_d = ST_PLAY;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_PLAY: begin
        score_d = score_add(score_q, bus.collision_trig);
        // a lost ball wins over a cleared board on the same tick
        if (ball_lost) begin
          state_d = ST_LOST;
          timer_d = '0;
        end else if (cleared) begin
          state_d = ST_CLEAR;
          timer_d = '0;
        end
      end
      ST_LOST: begin
        if (timer_q == TW'(PAUSE_TICKS - 1)) begin
          timer_d = '0;
          lives_d = lives_q - 2'd1;
          state_d = (lives_q == 2'd1) ? ST_OVER : ST_SERVE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_CLEAR: begin
        if (timer_q == TW'(PAUSE_TICKS - 1)) begin
          timer_d = '0;
          if (level_q == 2'(LEVELS - 1)) begin
            state_d = ST_WIN;
          end else begin
            level_d      = level_q + 2'd1;
            state_d      = ST_LOAD;
            brick_load_d = 1'b1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_OVER, ST_WIN: begin
        if (start_pulse) begin
          state_d = ST_MENU;
        end
      end
      default: state_d = ST_MENU;
    endcase
  end

  // Sequencer registers; rst also drops brick_load without waiting for a tick
  always_ff @(posedge clk_22 or posedge rst) begin
    if (rst) begin
      state_q      <= ST_MENU;
      lives_q      <= 2'(LIVES);
      level_q      <= 2'd0;
      score_q      <= 14'd0;
      timer_q      <= '0;
      brick_load_q <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lives_q      <= lives_d;
      level_q      <= level_d;
      score_q      <= score_d;
      timer_q      <= timer_d;
      brick_load_q <= brick_load_d;
      start_q      <= start_d;
    end
  end

  skill_award #(
    .SKILL_STEP (SKILL_STEP)
  ) u_skill_award (
    .clk_22 (clk_22),
    .rst    (rst),
    .en     (in_play),
    .clear  (game_start),
    .pts    (bus.collision_trig),
    .skill  (skill_w)
  );

  // A grant earned on the tick that leaves PLAY would land in LOST/CLEAR;
  // skills are only meaningful to ball_control during PLAY, so mask it.
  assign bus.skill         = skill_w & {3{in_play}};
  assign bus.state         = state_q;
  assign bus.lives         = lives_q;
  assign bus.level         = level_q;
  assign bus.score         = score_q;
  assign bus.brick_load    = brick_load_q;
  assign bus.brick_pattern = level_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: a table of PLAY-phase vectors plus
// hand-written sequences for serve timing, lives, levels, saturation and reset.
module tb_game_flow_ctrl;
  import game_pkg::*;

  logic clk_22;
  logic rst;

  game_flow_ctrl_if bus ();

  game_flow_ctrl dut (
    .clk_22 (clk_22),
    .rst    (rst),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [3:0]  coll;
    logic [9:0]  y;
    logic [9:0]  vy;
    logic        dn;
    logic        no_bricks;
    logic [2:0]  e_state;
    logic [13:0] e_score;
    logic [2:0]  e_skill;
  } vec_t;

  vec_t       vecs [9];
  logic [2:0] exp_q [$];
  int         n_vec;
  int         n_err;

  // clock
  initial clk_22 = 1'b0;
  always #5 clk_22 = ~clk_22;

  task automatic tick();
    @(posedge clk_22);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_bricks(input logic none);
    bus.bricks = none ? '0 : {1440{1'b1}};
  endtask

  task automatic set_ball(input logic [9:0] y, input logic [9:0] vy, input logic dn);
    bus.ball_y        = y;
    bus.ball_vy       = vy;
    bus.ball_dir_down = dn;
  endtask

  // tick until state==tgt or bound ticks have passed; n = ticks taken
  task automatic wait_state(input logic [2:0] tgt, input int bound, output int n);
    n = 0;
    while (bus.state != tgt && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic press_start();
    bus.start_btn = 1'b1;
    tick();
    bus.start_btn = 1'b0;
  endtask

  task automatic do_load();
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
  endtask

  initial begin
    int n;
    n_vec = 0;
    n_err = 0;

    //                coll  y    vy  dn nb  state     score  skill
    vecs[0] = '{4'd7,  10'd100, 10'd2, 1'b1, 1'b0, ST_PLAY, 14'd7,  3'b000};
    vecs[1] = '{4'd7,  10'd100, 10'd2, 1'b1, 1'b0, ST_PLAY, 14'd14, 3'b000};
    vecs[2] = '{4'd7,  10'd100, 10'd2, 1'b1, 1'b0, ST_PLAY, 14'd21, 3'b001};
    vecs[3] = '{4'd10, 10'd100, 10'd2, 1'b1, 1'b0, ST_PLAY, 14'd31, 3'b000};
    vecs[4] = '{4'd10, 10'd100, 10'd2, 1'b1, 1'b0, ST_PLAY, 14'd41, 3'b010};
    vecs[5] = '{4'd0,  10'd100, 10'd2, 1'b1, 1'b0, ST_PLAY, 14'd41, 3'b000};
    vecs[6] = '{4'd3,  10'd515, 10'd9, 1'b0, 1'b0, ST_PLAY, 14'd44, 3'b000};
    vecs[7] = '{4'd0,  10'd511, 10'd9, 1'b1, 1'b0, ST_PLAY, 14'd44, 3'b000};
    vecs[8] = '{4'd2,  10'd515, 10'd9, 1'b1, 1'b0, ST_LOST, 14'd46, 3'b000};

    // reset
    rst                = 1'b1;
    bus.start_btn      = 1'b0;
    bus.collision_trig = 4'd0;
    bus.load_done      = 1'b0;
    set_ball(10'd100, 10'd2, 1'b0);
    set_bricks(1'b0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_state", bus.state, ST_MENU);
    chk("rst_lives", bus.lives, 3);
    chk("rst_level", bus.level, 0);
    chk("rst_score", bus.score, 0);
    chk("rst_skill", bus.skill, 0);
    chk("rst_brick_load", bus.brick_load, 0);

    // start held 5 ticks: one pulse, MENU -> LOAD
    set_bricks(1'b0);
    bus.start_btn = 1'b1;
    tick();
    chk("start_load_state", bus.state, ST_LOAD);
    chk("start_brick_load", bus.brick_load, 1);
    repeat (4) tick();
    bus.start_btn = 1'b0;
    chk("load_holds", bus.state, ST_LOAD);
    do_load();
    chk("load_to_serve", bus.state, ST_SERVE);
    chk("load_drop", bus.brick_load, 0);

    // auto serve after 48 ticks
    set_bricks(1'b0);
    set_bricks(1'b1 == 1'b0);
    bus.bricks = {1440{1'b1}};
    wait_state(ST_PLAY, 100, n);
    chk("auto_serve_ticks", n, 48);
    chk("auto_serve_state", bus.state, ST_PLAY);

    // table-driven PLAY vectors
    for (int i = 0; i < 9; i++) begin
      bus.collision_trig = vecs[i].coll;
      set_ball(vecs[i].y, vecs[i].vy, vecs[i].dn);
      set_bricks(vecs[i].no_bricks);
      exp_q.push_back(vecs[i].e_skill);
      tick();
      chk($sformatf("vec%0d_state", i), bus.state, vecs[i].e_state);
      chk($sformatf("vec%0d_score", i), bus.score, vecs[i].e_score);
      chk($sformatf("vec%0d_skill", i), bus.skill, exp_q.pop_front());
    end
    bus.collision_trig = 4'd0;
    set_ball(10'd100, 10'd2, 1'b0);

    // LOST dwell, lives 3 -> 2
    wait_state(ST_SERVE, 40, n);
    chk("lost_dwell", n, 24);
    chk("lives_2", bus.lives, 2);

    // serve by button after 10 ticks
    repeat (10) tick();
    chk("serve_wait10", bus.state, ST_SERVE);
    press_start();
    chk("serve_btn_play", bus.state, ST_PLAY);

    // lost and cleared on the same tick -> LOST
    set_ball(10'd515, 10'd9, 1'b1);
    set_bricks(1'b1);
    tick();
    chk("lost_beats_clear", bus.state, ST_LOST);
    set_ball(10'd100, 10'd2, 1'b0);
    set_bricks(1'b0);
    wait_state(ST_SERVE, 40, n);
    chk("lives_1", bus.lives, 1);
    wait_state(ST_PLAY, 100, n);
    chk("auto_serve_ticks2", n, 48);
    set_ball(10'd515, 10'd9, 1'b1);
    tick();
    set_ball(10'd100, 10'd2, 1'b0);
    wait_state(ST_OVER, 40, n);
    chk("over_dwell", n, 24);
    chk("over_state", bus.state, ST_OVER);
    chk("over_lives", bus.lives, 0);
    chk("over_score_kept", bus.score, 46);

    // OVER -> MENU; held button must not also start a game
    bus.start_btn = 1'b1;
    tick();
    chk("over_to_menu", bus.state, ST_MENU);
    tick();
    chk("held_no_repulse", bus.state, ST_MENU);
    chk("menu_score_kept", bus.score, 46);
    bus.start_btn = 1'b0;
    tick();
    press_start();
    chk("restart_load", bus.state, ST_LOAD);
    chk("restart_lives", bus.lives, 3);
    chk("restart_score", bus.score, 0);
    do_load();
    press_start();
    chk("restart_play", bus.state, ST_PLAY);

    // score saturation
    bus.collision_trig = 4'd15;
    repeat (666) tick();
    bus.collision_trig = 4'd5;
    tick();
    chk("score_9995", bus.score, 9995);
    bus.collision_trig = 4'd12;
    tick();
    chk("score_sat", bus.score, 9999);
    bus.collision_trig = 4'd15;
    tick();
    chk("score_sat_hold", bus.score, 9999);
    bus.collision_trig = 4'd0;

    // clear all three levels -> WIN
    for (int lv = 0; lv < 3; lv++) begin
      set_bricks(1'b1);
      tick();
      chk($sformatf("clear%0d_state", lv), bus.state, ST_CLEAR);
      set_bricks(1'b0);
      if (lv < 2) begin
        wait_state(ST_LOAD, 40, n);
        chk($sformatf("clear%0d_dwell", lv), n, 24);
        chk($sformatf("level%0d", lv + 1), bus.level, lv + 1);
        chk($sformatf("pattern%0d", lv + 1), bus.brick_pattern, lv + 1);
        chk($sformatf("reload%0d", lv + 1), bus.brick_load, 1);
        do_load();
        press_start();
        chk($sformatf("play_lv%0d", lv + 1), bus.state, ST_PLAY);
      end else begin
        wait_state(ST_WIN, 40, n);
        chk("win_dwell", n, 24);
        chk("win_state", bus.state, ST_WIN);
        chk("win_level", bus.level, 2);
        chk("win_score", bus.score, 9999);
      end
    end

    // back to a fresh game, then async reset in LOAD
    press_start();
    chk("win_to_menu", bus.state, ST_MENU);
    tick();
    press_start();
    chk("pre_rst_load", bus.brick_load, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", bus.state, ST_MENU);
    chk("async_rst_brick_load", bus.brick_load, 0);
    chk("async_rst_score", bus.score, 0);
    tick();
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
